// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM encoding,
// default geometry and the guard width used by the saturating accumulators.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUS_WIDTH  = 16;
    localparam int DEF_DIM        = 4;

    // One extra bit is enough to see overflow when adding two BUS_WIDTH values.
    localparam int SAT_GUARD_BITS = 1;

    // The last operand pair reaches PE(DIM-1,DIM-1) 2*DIM-2 edges after the
    // final beat is accepted.
    function automatic int drain_last(input int dim);
        return 2 * dim - 2;
    endfunction

endpackage

// File: rtl/matmul_engine_pe_sat.sv
// Single processing element: signed multiply, saturating accumulate with a
// sticky overflow flag, and registered pass-through of both operands.
module pe_sat
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [BUS_WIDTH-1:0]  init_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic                  a_valid_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    output logic [BUS_WIDTH-1:0]  acc_o,
    output logic                  flag_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = BUS_WIDTH + SAT_GUARD_BITS;

    logic [BUS_WIDTH-1:0]  acc_q, acc_d;
    logic                  flag_q, flag_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    logic signed [PW-1:0] prod;
    logic        [SW-1:0] sum;
    logic                 overflow;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign sum      = {{SAT_GUARD_BITS{acc_q[BUS_WIDTH-1]}}, acc_q}
                    + {{(SW-PW){prod[PW-1]}}, prod};
    assign overflow = sum[SW-1] != sum[BUS_WIDTH-1];

    always_comb begin
        acc_d     = acc_q;
        flag_d    = flag_q;
        a_d       = a_i;
        a_valid_d = a_valid_i;
        b_d       = b_i;
        b_valid_d = b_valid_i;
        if (load_i) begin
            acc_d  = init_i;
            flag_d = 1'b0;
        end else if (a_valid_i && b_valid_i) begin
            if (overflow) begin
                // The guard bit holds the true sign of the overflowed sum.
                acc_d  = sum[SW-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                   : {1'b0, {(BUS_WIDTH-1){1'b1}}};
                flag_d = 1'b1;
            end else begin
                acc_d = sum[BUS_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            flag_q    <= 1'b0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            b_q       <= '0;
            b_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            flag_q    <= flag_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            b_q       <= b_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign a_o       = a_q;
    assign a_valid_o = a_valid_q;
    assign b_o       = b_q;
    assign b_valid_o = b_valid_q;
    assign acc_o     = acc_q;
    assign flag_o    = flag_q;

endmodule

// File: rtl/matmul_engine.sv
// Output-stationary DIMxDIM systolic matrix multiplier: operand beats are
// skewed into a PE grid, results stay in the PE accumulators.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int DIM        = DEF_DIM
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic [DIM*DATA_WIDTH-1:0]     a_col_i,
    input  logic [DIM*DATA_WIDTH-1:0]     b_row_i,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  logic [DIM*DIM*BUS_WIDTH-1:0]  c_i,
    output logic [DIM*DIM*BUS_WIDTH-1:0]  m_o,
    output logic [DIM*DIM-1:0]            flags_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(DIM+1)-1:0]      beat_cnt_o
);

    localparam int CW  = $clog2(DIM + 1);
    localparam int DCW = $clog2(2 * DIM);

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
    logic            op_ready_q, op_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic start_ok;
    logic accept;

    logic [DATA_WIDTH-1:0] a_h [DIM][DIM];
    logic                  av_h [DIM][DIM];
    logic [DATA_WIDTH-1:0] b_v [DIM][DIM];
    logic                  bv_v [DIM][DIM];
    logic [DATA_WIDTH:0]   a_sink_unused [DIM];
    logic [DATA_WIDTH:0]   b_sink_unused [DIM];

    assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept   = op_valid_i && op_ready_q;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    state_d    = ST_LOAD;
                    beat_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(DIM - 1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DCW'(drain_last(DIM))) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        op_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign op_ready_o = op_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign beat_cnt_o = beat_cnt_q;

    // Row i of A and column i of B share the same i-stage delay line shape;
    // each stage carries {valid, data}.
    for (genvar i = 0; i < DIM; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_h[0][0]  = a_col_i[DATA_WIDTH-1:0];
            assign av_h[0][0] = accept;
            assign b_v[0][0]  = b_row_i[DATA_WIDTH-1:0];
            assign bv_v[0][0] = accept;
        end else begin : g_delay
            logic [DATA_WIDTH:0] a_sk_q [i];
            logic [DATA_WIDTH:0] a_sk_d [i];
            logic [DATA_WIDTH:0] b_sk_q [i];
            logic [DATA_WIDTH:0] b_sk_d [i];

            always_comb begin
                a_sk_d[0] = {accept, a_col_i[i*DATA_WIDTH +: DATA_WIDTH]};
                b_sk_d[0] = {accept, b_row_i[i*DATA_WIDTH +: DATA_WIDTH]};
                for (int s = 1; s < i; s++) begin
                    a_sk_d[s] = a_sk_q[s-1];
                    b_sk_d[s] = b_sk_q[s-1];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int s = 0; s < i; s++) begin
                        a_sk_q[s] <= '0;
                        b_sk_q[s] <= '0;
                    end
                end else begin
                    a_sk_q <= a_sk_d;
                    b_sk_q <= b_sk_d;
                end
            end

            assign a_h[i][0]  = a_sk_q[i-1][DATA_WIDTH-1:0];
            assign av_h[i][0] = a_sk_q[i-1][DATA_WIDTH];
            assign b_v[0][i]  = b_sk_q[i-1][DATA_WIDTH-1:0];
            assign bv_v[0][i] = b_sk_q[i-1][DATA_WIDTH];
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_fwd, b_fwd;
            logic                  a_fwd_v, b_fwd_v;

            pe_sat #(
                .DATA_WIDTH (DATA_WIDTH),
                .BUS_WIDTH  (BUS_WIDTH)
            ) u_pe (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .load_i    (start_ok),
                .init_i    (mode_i ? c_i[(i*DIM+j)*BUS_WIDTH +: BUS_WIDTH] : '0),
                .a_i       (a_h[i][j]),
                .a_valid_i (av_h[i][j]),
                .b_i       (b_v[i][j]),
                .b_valid_i (bv_v[i][j]),
                .a_o       (a_fwd),
                .a_valid_o (a_fwd_v),
                .b_o       (b_fwd),
                .b_valid_o (b_fwd_v),
                .acc_o     (m_o[(i*DIM+j)*BUS_WIDTH +: BUS_WIDTH]),
                .flag_o    (flags_o[i*DIM+j])
            );

            if (j < DIM - 1) begin : g_pass_a
                assign a_h[i][j+1]  = a_fwd;
                assign av_h[i][j+1] = a_fwd_v;
            end else begin : g_sink_a
                assign a_sink_unused[i] = {a_fwd_v, a_fwd};
            end

            if (i < DIM - 1) begin : g_pass_b
                assign b_v[i+1][j]  = b_fwd;
                assign bv_v[i+1][j] = b_fwd_v;
            end else begin : g_sink_b
                assign b_sink_unused[j] = {b_fwd_v, b_fwd};
            end
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed self-checking bench for matmul_engine at DIM=4, 8-bit operands,
// 16-bit accumulators.
module tb_matmul_engine;

    localparam int DW  = 8;
    localparam int BW  = 16;
    localparam int DIM = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [DIM*DW-1:0]      a_col;
    logic [DIM*DW-1:0]      b_row;
    logic                   op_valid;
    logic                   op_ready;
    logic [DIM*DIM*BW-1:0]  c_in;
    logic [DIM*DIM*BW-1:0]  m_out;
    logic [DIM*DIM-1:0]     flags;
    logic                   busy;
    logic                   done;
    logic [2:0]             beat_cnt;

    int a_m [DIM][DIM];
    int b_m [DIM][DIM];
    int vectors     = 0;
    int miscompares = 0;
    int lat;

    logic [DIM*DIM*BW-1:0] exp_m;
    logic [DIM*DIM-1:0]    exp_f;

    always #5 clk = ~clk;

    matmul_engine #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .DIM        (DIM)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mode_i     (mode),
        .a_col_i    (a_col),
        .b_row_i    (b_row),
        .op_valid_i (op_valid),
        .op_ready_o (op_ready),
        .c_i        (c_in),
        .m_o        (m_out),
        .flags_o    (flags),
        .busy_o     (busy),
        .done_o     (done),
        .beat_cnt_o (beat_cnt)
    );

    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_identity_seq();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = i * 4 + j;
            end
    endtask

    task automatic set_all(input int av, input int bv);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                a_m[i][j] = av;
                b_m[i][j] = bv;
            end
    endtask

    task automatic fill_c(input int v);
        for (int idx = 0; idx < DIM*DIM; idx++)
            c_in[idx*BW +: BW] = v[15:0];
    endtask

    // Reference: element-wise accumulation with saturation after every step.
    task automatic build_model(input bit md, input int cval);
        int acc;
        bit f;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                acc = md ? cval : 0;
                f   = 1'b0;
                for (int k = 0; k < DIM; k++) begin
                    acc = acc + a_m[i][k] * b_m[k][j];
                    if (acc > 32767) begin
                        acc = 32767;
                        f   = 1'b1;
                    end else if (acc < -32768) begin
                        acc = -32768;
                        f   = 1'b1;
                    end
                end
                exp_m[(i*DIM+j)*BW +: BW] = acc[15:0];
                exp_f[i*DIM+j]            = f;
            end
    endtask

    task automatic do_start(input bit md, input int cval);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        fill_c(cval);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ready_after_start", {253'd0, op_ready, busy, done}, 256'b110);
    endtask

    task automatic feed_beats(input int gap, input bit glitch);
        for (int k = 0; k < DIM; k++) begin
            start = 1'b0;
            if (glitch && k == 2)
                checkOutput("start_in_load_ignored", {250'd0, op_ready, busy, done, beat_cnt},
                            {250'd0, 1'b1, 1'b1, 1'b0, 3'd2});
            if (k == 2 && gap > 0) begin
                op_valid = 1'b0;
                repeat (gap) @(negedge clk);
                checkOutput("bubble_beat_cnt", {253'd0, beat_cnt}, 256'd2);
            end
            op_valid = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                a_col[i*DW +: DW] = 8'(a_m[i][k]);
                b_row[i*DW +: DW] = 8'(b_m[k][i]);
            end
            if (glitch && k == 1) begin
                start = 1'b1;
                mode  = ~mode;
                fill_c(77);
            end
            @(posedge clk);
            if (k < DIM - 1) @(negedge clk);
        end
        #1;
        op_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done && n < 40);
    endtask

    task automatic applyStimulus(input bit md, input int cval, input int gap,
                                 input bit glitch, output int n);
        do_start(md, cval);
        feed_beats(gap, glitch);
        wait_done(n);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        op_valid = 1'b0;
        a_col    = '0;
        b_row    = '0;
        c_in     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_m", m_out, 256'd0);
        checkOutput("reset_flags", {240'd0, flags}, 256'd0);
        checkOutput("reset_ctrl", {250'd0, op_ready, busy, done, beat_cnt}, 256'd0);
        rst = 1'b0;

        $display("[TB] identity x sequence, mode 0");
        set_identity_seq();
        build_model(1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, lat);
        checkOutput("t1_latency", 256'(lat), 256'd7);
        checkOutput("t1_m", m_out, exp_m);
        checkOutput("t1_m32", {240'd0, m_out[(3*DIM+2)*BW +: BW]}, 256'd14);
        checkOutput("t1_flags", {240'd0, flags}, 256'd0);
        checkOutput("t1_beat_cnt", {253'd0, beat_cnt}, 256'd4);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", {254'd0, done, busy}, 256'd0);

        $display("[TB] ones x ones + 5, mode 1");
        set_all(1, 1);
        build_model(1'b1, 5);
        applyStimulus(1'b1, 5, 0, 1'b0, lat);
        checkOutput("t2_latency", 256'(lat), 256'd7);
        checkOutput("t2_m", m_out, exp_m);
        checkOutput("t2_m00", {240'd0, m_out[BW-1:0]}, 256'd9);
        checkOutput("t2_flags", {240'd0, flags}, 256'd0);

        $display("[TB] -128 x -128 saturation");
        set_all(-128, -128);
        build_model(1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, lat);
        checkOutput("t3_m", m_out, exp_m);
        checkOutput("t3_m33", {240'd0, m_out[(DIM*DIM-1)*BW +: BW]}, 256'h7fff);
        checkOutput("t3_flags", {240'd0, flags}, 256'hffff);

        $display("[TB] identity with bubbles");
        set_identity_seq();
        build_model(1'b0, 0);
        applyStimulus(1'b0, 0, 3, 1'b0, lat);
        checkOutput("t4_latency", 256'(lat), 256'd7);
        checkOutput("t4_m", m_out, exp_m);
        checkOutput("t4_flags", {240'd0, flags}, 256'd0);

        $display("[TB] start pulsed during load");
        set_all(1, 1);
        build_model(1'b1, 5);
        applyStimulus(1'b1, 5, 0, 1'b1, lat);
        checkOutput("t5_latency", 256'(lat), 256'd7);
        checkOutput("t5_m", m_out, exp_m);
        checkOutput("t5_m12", {240'd0, m_out[(1*DIM+2)*BW +: BW]}, 256'd9);

        $display("[TB] reset during drain");
        set_all(1, 1);
        do_start(1'b1, 5);
        feed_beats(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_rst_m", m_out, 256'd0);
        checkOutput("t6_rst_flags", {240'd0, flags}, 256'd0);
        checkOutput("t6_rst_ctrl", {250'd0, op_ready, busy, done, beat_cnt}, 256'd0);
        rst = 1'b0;
        set_identity_seq();
        build_model(1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, lat);
        checkOutput("t6_latency", 256'(lat), 256'd7);
        checkOutput("t6_m", m_out, exp_m);

        $display("[TB] start coincident with done");
        start = 1'b1;
        mode  = 1'b1;
        set_all(1, 1);
        fill_c(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int idx = 0; idx < DIM*DIM; idx++)
            exp_m[idx*BW +: BW] = 16'd5;
        checkOutput("t7_reload_m", m_out, exp_m);
        checkOutput("t7_reload_ctrl", {250'd0, op_ready, busy, done, beat_cnt},
                    {250'd0, 1'b1, 1'b1, 1'b0, 3'd0});
        @(negedge clk);
        build_model(1'b1, 5);
        feed_beats(0, 1'b0);
        wait_done(lat);
        checkOutput("t7_latency", 256'(lat), 256'd7);
        checkOutput("t7_m", m_out, exp_m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
